// File: rtl/nes_pkg.sv
// Shared definitions for the NES gamepad front end and the display stage that consumes it.
package nes_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } nes_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs, with a selectable reset level.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/nes_controller_reader.sv
// Latch/clock sequencer for the NES 4021 pad: one frame per poll period, eight inverted
// samples shifted in LSB first, published as a parallel byte with a one-cycle strobe.
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833_333
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   nesData,
    output logic                   nesLatch,
    output logic                   nesClk,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   buttonsValid
);

    localparam int PHASE_MAX = max_int(LATCH_CYCLES, HALF_CYCLES);
    localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int POLL_W    = $clog2(POLL_CYCLES);
    localparam int BIT_W     = $clog2(NUM_BUTTONS);

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(NUM_BUTTONS - 1);

    nes_state_e             state_q, state_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [POLL_W-1:0]      poll_q, poll_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [NUM_BUTTONS-1:0] shift_q, shift_d;
    logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
    logic                   latch_q, latch_d;
    logic                   nes_clk_q, nes_clk_d;
    logic                   valid_q, valid_d;
    logic                   data_sync;
    logic                   sample;
    logic                   frame_start;

    // Idles released (pull-up level) so reset never looks like a pressed button.
    sync2 #(
        .RESET_VAL(1'b1)
    ) u_data_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (nesData),
        .q_o  (data_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (poll_q == POLL_LAST) state_d = LATCH;
            LATCH:   if (phase_q == LATCH_LAST) state_d = LOW;
            LOW:     if (phase_q == HALF_LAST) state_d = (bit_q == BIT_LAST) ? DONE : HIGH;
            HIGH:    if (phase_q == HALF_LAST) state_d = LOW;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q and never glitch.
    always_comb begin
        latch_d   = (state_d == LATCH);
        nes_clk_d = (state_d == HIGH);
        valid_d   = (state_d == DONE);
        buttons_d = (state_d == DONE) ? shift_d : buttons_q;
    end

    always_comb begin
        sample      = (state_q == LOW) && (phase_q == HALF_LAST);
        frame_start = (state_d == LATCH) && (state_q != LATCH);
        phase_d     = (state_d != state_q) ? '0 : phase_q + 1'b1;
        poll_d      = (frame_start || poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;

        bit_d = bit_q;
        if (state_q == IDLE) begin
            bit_d = '0;
        end else if (state_q == HIGH && phase_q == HALF_LAST) begin
            bit_d = bit_q + 1'b1;
        end

        shift_d = sample ? {~data_sync, shift_q[NUM_BUTTONS-1:1]} : shift_q;
    end

    // Poll counter resets to its last value so the first frame starts right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= '0;
            poll_q    <= POLL_LAST;
            bit_q     <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            latch_q   <= 1'b0;
            nes_clk_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            poll_q    <= poll_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            latch_q   <= latch_d;
            nes_clk_q <= nes_clk_d;
            valid_q   <= valid_d;
        end
    end

    assign nesLatch     = latch_q;
    assign nesClk       = nes_clk_q;
    assign buttons      = buttons_q;
    assign buttonsValid = valid_q;

endmodule

// File: doc/nes_controller_reader.md
# nes_controller_reader

Serial front end for the NES gamepad. Generates the controller latch and clock waveforms, samples the 4021 shift-register output once per poll period, and presents the eight button states as an active-high parallel byte with a one-cycle valid strobe. Sits directly upstream of the button-capture and seven-segment stage. It replaces the separate clock, latch and shift-register blocks with one self-consistent sequencer, so latch, clock and sampling can never drift apart.

## Interface
- LATCH_CYCLES, 600: nesLatch high time in clk cycles (12 µs at 50 MHz).
- HALF_CYCLES, 300: duration of each nesClk phase (6 µs at 50 MHz).
- POLL_CYCLES, 833_333: frame start-to-start period (60 Hz at 50 MHz). Must be ≥ LATCH_CYCLES + 15·HALF_CYCLES + 2.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- nesData  in  1  controller serial data, asynchronous, active-low (0 = pressed).
- nesLatch  out  1  parallel-load pulse to the controller.
- nesClk  out  1  shift clock to the controller; idles low.
- buttons  out  8  active-high pressed flags: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- buttonsValid  out  1  one-cycle pulse when buttons has just been updated.

## Operation
- nesData passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- FSM states:
  - IDLE: waits for the poll counter to expire, then goes to LATCH.
  - LATCH: nesLatch=1 for LATCH_CYCLES.
  - LOW: nesClk=0 for HALF_CYCLES. Samples bit k on the last cycle. If k=7, goes to DONE; otherwise goes to HIGH.
  - HIGH: nesClk=1 for HALF_CYCLES. The controller shifts on the rising edge. Then increments k and returns to LOW.
  - DONE: one cycle. Loads buttons, pulses buttonsValid, returns to IDLE.
- Sampled bits are inverted into an internal shift register, LSB first (A first). buttons changes only in DONE and holds between frames.
- Poll counter: free-running modulo POLL_CYCLES, zeroed at each frame start. Frame starts are exactly POLL_CYCLES apart.
- No controller present (pull-up, nesData=1): every frame reads 8'h00. No special-casing.
- Reset values: nesLatch=0, nesClk=0, buttons=8'h00, buttonsValid=0, bit index 0, synchronizer flops 1 (released).
- Reset mid-frame aborts the frame. Outputs take their reset values on the next edge. No valid pulse for the aborted frame. Partial data is discarded.
- First frame begins on the first cycle after reset deasserts.

## Timing
- Frame cycle 0 = first cycle with nesLatch=1. L=LATCH_CYCLES, H=HALF_CYCLES.
- nesLatch=1 on cycles 0..L−1.
- Low phase k (k=0..7): cycles L+2kH .. L+2kH+H−1. Sample on the final cycle.
- High phase k (k=0..6): cycles L+(2k+1)H .. L+(2k+2)H−1. There are exactly 7 nesClk pulses per frame.
- Last sample at cycle L+15H−1. buttons and buttonsValid are visible at cycle L+15H, which is the latency from frame start.
- The next frame's cycle 0 is at cycle POLL_CYCLES.
- nesLatch and nesClk are registered outputs, glitch-free, and never high simultaneously.
- Synchronizer delay is 2 cycles. A bit must be stable for at least 3 cycles before its sample cycle. Changes after the sample cycle are ignored.

## Structure
- Shared package nes_pkg holds:
  - state enum (IDLE, LATCH, LOW, HIGH, DONE);
  - button index constants (BTN_A … BTN_RIGHT);
  - NUM_BUTTONS = 8.
- The display stage imports the same package.
- Natural sub-module: sync2, a 2-flop synchronizer with a reset value parameter. It is reused for other asynchronous inputs.
- Cycle counters, FSM and shift register live in nes_controller_reader. There is one phase counter, sized $clog2(max(L,H)), and one poll counter, sized $clog2(POLL_CYCLES).

## Test plan
All scenarios use L=4, H=2, POLL_CYCLES=64. Frame length is L+15H=34.

- Reset held 5 cycles → nesLatch=0, nesClk=0, buttons=00, buttonsValid=0 throughout. After release, nesLatch=1 on cycles 0–3.
- Controller model with A and Start pressed (serial bits 0,1,1,0,1,1,1,1) → buttons=8'h09 and buttonsValid=1 for exactly one cycle at frame cycle 34. Exactly 7 nesClk rising edges.
- nesData tied 1 → buttons=8'h00. buttonsValid pulses every 64 cycles (cycles 34, 98, 162).
- Frame 1 all pressed, frame 2 all released → buttons=8'hFF after pulse 1 and 8'h00 after pulse 2. buttons stable between pulses.
- Reset asserted at frame cycle 20 for 2 cycles → outputs zero on the next edge, no valid pulse. A new latch starts on the first cycle after release, and a full frame decodes correctly.
- nesData toggled on the cycle after each sample for pattern 8'hA5 (active-high) → buttons=8'hA5. Post-sample glitches are ignored.
